// File: rtl/word_aligner_pkg.sv
// Shared constants and types for the K28.5 word aligner.
// COMMA_* are in decoder input bit order, so they compare directly against O[9:0].
package word_aligner_pkg;

    localparam int WORD_W = 20;
    localparam int SYM_W  = 10;

    localparam logic [SYM_W-1:0] COMMA_NEG = 10'h17C;
    localparam logic [SYM_W-1:0] COMMA_POS = 10'h283;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_comma(input logic [SYM_W-1:0] sym);
        return (sym == COMMA_NEG) || (sym == COMMA_POS);
    endfunction

endpackage

// File: rtl/word_aligner_comma_finder.sv
// Combinational comma search over every bit offset of the 40-bit window.
// first_k reports the lowest matching offset (0 when nothing matches).
module comma_finder
    import word_aligner_pkg::*;
(
    input  logic [2*WORD_W-1:0] win,
    output logic [WORD_W-1:0]   match,
    output logic [4:0]          first_k,
    output logic                any_hit
);

    for (genvar k = 0; k < WORD_W; k++) begin : g_off
        assign match[k] = is_comma(win[2*WORD_W-1-SYM_W-k -: SYM_W]);
    end

    // Scan downwards so the lowest offset is the last one written.
    always_comb begin
        first_k = '0;
        for (int k = WORD_W - 1; k >= 0; k--) begin
            if (match[k]) first_k = 5'(k);
        end
    end

    assign any_hit = |match;

endmodule

// File: rtl/word_aligner.sv
// Comma-hunting word aligner feeding the 8b10b decoder: locks a bit offset
// so commas land in O[9:0]. Optional stats outputs under WORD_ALIGNER_STATS_EN.
module word_aligner
    import word_aligner_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned LOSS_COUNT   = 3,
    parameter int unsigned HUNT_TIMEOUT = 256
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WORD_W-1:0] I,
    input  logic              Resync,
    output logic [WORD_W-1:0] O,
    output logic              Valid,
    output logic              Locked,
    output logic [4:0]        Offset,
    output logic              CommaSeen
`ifdef WORD_ALIGNER_STATS_EN
    ,
    output logic [15:0]       LossCount,
    output logic [15:0]       RealignCount
`endif
);

    localparam int TMR_W = $clog2(HUNT_TIMEOUT + 1);

    logic [WORD_W-1:0]   p_q;
    logic                primed_q;
    logic [2*WORD_W-1:0] window;
    logic [WORD_W-1:0]   match;
    logic [4:0]          first_k;
    logic                any_raw, any_hit, at_off;

    align_state_t        state_q, state_d;
    logic [3:0]          cnt_q, cnt_d, cnt_inc;
    logic [3:0]          miss_q, miss_d, miss_inc;
    logic [TMR_W-1:0]    tmr_q, tmr_d, tmr_inc;
    logic [4:0]          off_d;

    assign window = {p_q, I};

    comma_finder u_finder (
        .win     (window),
        .match   (match),
        .first_k (first_k),
        .any_hit (any_raw)
    );

    // The first word after reset only fills P, so its window is not trusted.
    assign any_hit = primed_q & any_raw;
    assign at_off  = primed_q & match[Offset];

    assign cnt_inc  = (cnt_q  == 4'hF)  ? cnt_q  : cnt_q  + 4'd1;
    assign miss_inc = (miss_q == 4'hF)  ? miss_q : miss_q + 4'd1;
    assign tmr_inc  = (tmr_q  == '1)    ? tmr_q  : tmr_q  + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        tmr_d   = tmr_q;
        off_d   = Offset;
        if (Resync) begin
            state_d = HUNT;
            cnt_d   = '0;
            miss_d  = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (any_hit) begin
                        off_d   = first_k;
                        cnt_d   = 4'd1;
                        tmr_d   = '0;
                        state_d = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (at_off) begin
                        tmr_d = '0;
                        if (32'(cnt_inc) >= LOCK_COUNT) begin
                            state_d = LOCKED;
                            cnt_d   = '0;
                            miss_d  = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (any_hit) begin
                        off_d = first_k;
                        cnt_d = 4'd1;
                        tmr_d = '0;
                    end else if (32'(tmr_inc) >= HUNT_TIMEOUT) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_inc;
                    end
                end
                LOCKED: begin
                    if (at_off) begin
                        miss_d = '0;
                    end else if (any_hit) begin
                        if (32'(miss_inc) >= LOSS_COUNT) begin
                            state_d = HUNT;
                            miss_d  = '0;
                            cnt_d   = '0;
                            tmr_d   = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            p_q       <= '0;
            primed_q  <= 1'b0;
            state_q   <= HUNT;
            cnt_q     <= '0;
            miss_q    <= '0;
            tmr_q     <= '0;
            Offset    <= '0;
            O         <= '0;
            Valid     <= 1'b0;
            Locked    <= 1'b0;
            CommaSeen <= 1'b0;
        end else begin
            p_q       <= I;
            primed_q  <= 1'b1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            tmr_q     <= tmr_d;
            Offset    <= off_d;
            O         <= window[(2*WORD_W-1) - int'(Offset) -: WORD_W];
            Valid     <= (state_d == LOCKED);
            Locked    <= (state_d == LOCKED);
            CommaSeen <= any_hit;
        end
    end

`ifdef WORD_ALIGNER_STATS_EN
    logic lost, realign;

    // A VERIFY stay with a new offset is only possible via a candidate restart.
    assign lost    = (state_q == LOCKED) && (state_d == HUNT);
    assign realign = (state_q == VERIFY) && (state_d == VERIFY) && (off_d != Offset);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            LossCount    <= '0;
            RealignCount <= '0;
        end else begin
            if (lost && LossCount != 16'hFFFF)       LossCount    <= LossCount + 16'd1;
            if (realign && RealignCount != 16'hFFFF) RealignCount <= RealignCount + 16'd1;
        end
    end
`endif

endmodule
